coin_acceptor: RTL and testbench
================================

# coin_acceptor

Front end of the vending path: conditions three raw coin-sensor lines and delivers each accepted coin to `vending_machine` as a clean single-cycle, one-hot pulse on `a`, `b` or `c`. Each line passes through a synchronizer, a debounce filter and a rising-edge detector. Coins are queued in arrival order and released one at a time with a guaranteed idle gap, so the downstream FSM never sees two coins in one cycle or coins while it is vending. The coin values are a = 1, b = 2 and c = 5 units.

## Interface
- DEB_CYCLES, 4: consecutive stable synchronized samples required to change a debounced level (1..255).
- GAP_CYCLES, 2: idle cycles forced after every output pulse (0..15).
- FIFO_DEPTH, 4: coin queue depth, power of two (2..16).
- clk  in  1  single system clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- coin_a_raw, coin_b_raw, coin_c_raw  in  1 each  asynchronous sensor lines; high while a coin is in the chute.
- hold  in  1  downstream busy (driven from `bottle`); while high, no coin is released.
- a, b, c  out  1 each  registered one-hot coin pulses to `vending_machine`.
- pending  out  $clog2(FIFO_DEPTH)+1  number of queued coins.
- overflow  out  1  sticky; set when a coin is dropped, cleared only by reset.

## Operation
- Per channel: 2-flop synchronizer, then debounce. The debounced level toggles after DEB_CYCLES consecutive synchronized samples that differ from it. Any agreeing sample clears the counter. A 0→1 transition of the debounced level is one coin event. Falling edges are ignored.
- Each channel has a 1-bit pending latch. An event sets it.
- Arbiter: each cycle, if any latch is set and the FIFO is not full, the highest-priority latch (c > b > a) is cleared and its 2-bit code is written. Simultaneous events therefore enter in order c, b, a over consecutive cycles.
- An event on a channel whose latch is still set is dropped and sets overflow. A latch that is set while the FIFO is full waits; it is not dropped.
- Output sequencer states:
  - IDLE: if FIFO is non-empty and hold = 0, pop and go to PULSE.
  - PULSE: drive exactly one of a/b/c high for one cycle. Go to GAP, or to IDLE if GAP_CYCLES = 0.
  - GAP: count GAP_CYCLES cycles with outputs low, then go to IDLE.
- hold is sampled only in IDLE. It never truncates a pulse or a gap already in progress.
- Same-cycle FIFO push and pop are both performed, and pending is unchanged.

## Timing
- Reset values: a = b = c = 0, overflow = 0, pending = 0, FIFO empty, all latches and debounce counters clear, debounced levels 0, state IDLE.
- Reset asserted mid-operation discards queued coins and any pulse in progress on the next edge. A raw line still high at reset release counts as a coin once it is debounced.
- Latency: raw line rises before edge k and stays high. With the queue empty, state IDLE and hold = 0, the output pulse is high during the cycle after edge k + DEB_CYCLES + 4.
- Each subsequent queued coin follows the previous pulse by exactly GAP_CYCLES + 1 cycles when hold = 0.
- pending updates on the same edge as the push or pop.
- Width: debounce counter 8 bits; gap counter 4 bits; pending saturates at FIFO_DEPTH.

## Configuration
- COIN_RETURN_EN defined:
  - Adds output `coin_return` (1 bit) and `return_code` (2 bits, a = 1, b = 2, c = 3).
  - Every dropped coin produces a one-cycle coin_return pulse on the drop cycle, with return_code identifying the channel. Both reset to 0.
  - overflow behaves as before.
- Not defined: the ports are absent, and a drop only sets overflow.

## Structure
- Shared package `coin_pkg`:
  - coin code typedef: NONE = 0, A = 1, B = 2, C = 3.
  - sequencer state enum: IDLE, PULSE, GAP.
  - coin value constants: 1, 2, 5.
- Sub-module `coin_debounce`: synchronizer, debounce counter and edge-detect for one channel, parameterised by DEB_CYCLES. Instantiated three times.
- FIFO, arbiter and sequencer stay in `coin_acceptor`.

## Test plan
- Reset then idle 50 cycles → a = b = c = 0, pending = 0, overflow = 0.
- coin_b_raw high 20 cycles with defaults → a single `b` pulse in the cycle after edge k+8; no other pulses.
- coin_a_raw toggling every 2 cycles for 30 cycles, DEB_CYCLES = 4 → no coin event; the level settling high afterwards → exactly one `a` pulse.
- coin_a_raw, coin_b_raw and coin_c_raw rising in the same cycle → pulses c, b, a in that order, each 3 cycles apart (GAP_CYCLES = 2).
- hold = 1 while 3 coins arrive → pending = 3 and no pulses; hold released → three pulses, pending counting down 2, 1, 0.
- hold = 1 with 6 distinct coins (FIFO_DEPTH = 4), then a repeat on a latched channel → overflow = 1; with COIN_RETURN_EN, one coin_return pulse carrying that channel's code.

Source files
------------

// File: rtl/coin_pkg.sv
// Shared coin codes, sequencer states and coin values for the coin acceptor path.
package coin_pkg;

  typedef enum logic [1:0] {
    COIN_NONE = 2'd0,
    COIN_A    = 2'd1,
    COIN_B    = 2'd2,
    COIN_C    = 2'd3
  } coin_code_t;

  typedef enum logic [1:0] {
    SEQ_IDLE  = 2'd0,
    SEQ_PULSE = 2'd1,
    SEQ_GAP   = 2'd2
  } seq_state_t;

  localparam int unsigned COIN_VAL_A = 1;
  localparam int unsigned COIN_VAL_B = 2;
  localparam int unsigned COIN_VAL_C = 5;

  function automatic int unsigned coin_value(input coin_code_t code);
    case (code)
      COIN_A:  return COIN_VAL_A;
      COIN_B:  return COIN_VAL_B;
      COIN_C:  return COIN_VAL_C;
      default: return 0;
    endcase
  endfunction

  // Bit order {c, b, a} matches the output pulse vector.
  function automatic logic [2:0] code_onehot(input coin_code_t code);
    case (code)
      COIN_A:  return 3'b001;
      COIN_B:  return 3'b010;
      COIN_C:  return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/coin_debounce.sv
// One sensor channel: 2-flop synchronizer, DEB_CYCLES debounce, single-cycle rising-edge event.
module coin_debounce
  import coin_pkg::*;
#(
  parameter int DEB_CYCLES = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic raw_i,
  output logic rise_o
);

  localparam logic [7:0] DEB_LAST = 8'(DEB_CYCLES - 1);

  logic       sync1_q, sync2_q;
  logic       level_q, level_d;
  logic       prev_q;
  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    level_d = level_q;
    cnt_d   = cnt_q;
    if (sync2_q == level_q) begin
      cnt_d = 8'd0;
    end else if (cnt_q == DEB_LAST) begin
      level_d = ~level_q;
      cnt_d   = 8'd0;
    end else begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      prev_q  <= 1'b0;
      cnt_q   <= 8'd0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      prev_q  <= level_q;
      cnt_q   <= cnt_d;
    end
  end

  assign rise_o = level_q & ~prev_q;

endmodule

// File: rtl/coin_acceptor.sv
// Conditions three coin sensors and releases queued coins as spaced one-hot pulses on a/b/c.
// Optional COIN_RETURN_EN adds coin_return/return_code reporting every dropped coin.
module coin_acceptor
  import coin_pkg::*;
#(
  parameter int DEB_CYCLES = 4,
  parameter int GAP_CYCLES = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          coin_a_raw,
  input  logic                          coin_b_raw,
  input  logic                          coin_c_raw,
  input  logic                          hold,
  output logic                          a,
  output logic                          b,
  output logic                          c,
  output logic [$clog2(FIFO_DEPTH):0]   pending,
  output logic                          overflow
`ifdef COIN_RETURN_EN
  ,
  output logic                          coin_return,
  output logic [1:0]                    return_code
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  localparam logic [3:0] GAP_LOAD = (GAP_CYCLES >= 2) ? 4'(GAP_CYCLES - 2) : 4'd0;

  logic [2:0] rise;

  coin_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_a (
    .clk_i (clk),
    .rst_ni(reset),
    .raw_i (coin_a_raw),
    .rise_o(rise[0])
  );

  coin_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_b (
    .clk_i (clk),
    .rst_ni(reset),
    .raw_i (coin_b_raw),
    .rise_o(rise[1])
  );

  coin_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_c (
    .clk_i (clk),
    .rst_ni(reset),
    .raw_i (coin_c_raw),
    .rise_o(rise[2])
  );

  coin_code_t   mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PW-1:0] cnt_q, cnt_d;
  logic          fifo_full, fifo_empty;

  logic [2:0]  latch_q, latch_d;
  logic [2:0]  grant, drop;
  logic        push, pop;
  coin_code_t  push_code;
  logic        overflow_q, overflow_d;

  seq_state_t  state_q, state_d;
  logic [3:0]  gap_q, gap_d;
  logic [2:0]  out_q, out_d;

  assign fifo_full  = (cnt_q == PW'(FIFO_DEPTH));
  assign fifo_empty = (cnt_q == '0);

  // Fixed priority c > b > a; a latch blocked by a full queue simply waits.
  always_comb begin
    grant     = 3'b000;
    push_code = COIN_NONE;
    if (!fifo_full) begin
      if (latch_q[2]) begin
        grant     = 3'b100;
        push_code = COIN_C;
      end else if (latch_q[1]) begin
        grant     = 3'b010;
        push_code = COIN_B;
      end else if (latch_q[0]) begin
        grant     = 3'b001;
        push_code = COIN_A;
      end
    end
    push       = |grant;
    drop       = rise & latch_q & ~grant;
    latch_d    = (latch_q & ~grant) | rise;
    overflow_d = overflow_q | (|drop);
  end

  // IDLE doubles as the last gap cycle, so GAP only covers GAP_CYCLES-1 cycles
  // and back-to-back coins land exactly GAP_CYCLES+1 cycles apart.
  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    out_d   = 3'b000;
    pop     = 1'b0;
    case (state_q)
      SEQ_IDLE: begin
        if (!fifo_empty && !hold) begin
          pop     = 1'b1;
          out_d   = code_onehot(mem_q[rd_ptr_q]);
          state_d = SEQ_PULSE;
        end
      end
      SEQ_PULSE: begin
        if (GAP_CYCLES >= 2) begin
          state_d = SEQ_GAP;
          gap_d   = GAP_LOAD;
        end else begin
          state_d = SEQ_IDLE;
        end
      end
      SEQ_GAP: begin
        if (gap_q == 4'd0) begin
          state_d = SEQ_IDLE;
        end else begin
          gap_d = gap_q - 4'd1;
        end
      end
      default: state_d = SEQ_IDLE;
    endcase
  end

  always_comb begin
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + PW'(1);
      2'b01:   cnt_d = cnt_q - PW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= push_code;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      latch_q    <= 3'b000;
      overflow_q <= 1'b0;
      state_q    <= SEQ_IDLE;
      gap_q      <= 4'd0;
      out_q      <= 3'b000;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      cnt_q      <= cnt_d;
      latch_q    <= latch_d;
      overflow_q <= overflow_d;
      state_q    <= state_d;
      gap_q      <= gap_d;
      out_q      <= out_d;
    end
  end

  assign a        = out_q[0];
  assign b        = out_q[1];
  assign c        = out_q[2];
  assign pending  = cnt_q;
  assign overflow = overflow_q;

`ifdef COIN_RETURN_EN
  // Reported in the drop cycle itself; the highest-priority channel wins a tie.
  always_comb begin
    coin_return = reset & (|drop);
    return_code = 2'b00;
    if (reset) begin
      if (drop[2])      return_code = COIN_C;
      else if (drop[1]) return_code = COIN_B;
      else if (drop[0]) return_code = COIN_A;
    end
  end
`endif

endmodule

// File: tb/tb_coin_acceptor.sv
// Directed bench for coin_acceptor: vector table for single coins plus hand-written multi-coin sequences.
module tb_coin_acceptor;
  import coin_pkg::*;

  localparam int DEB   = 4;
  localparam int GAP   = 2;
  localparam int DEPTH = 4;
  localparam int LAT   = DEB + 5;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic coin_a_raw = 1'b0, coin_b_raw = 1'b0, coin_c_raw = 1'b0;
  logic hold = 1'b0;
  logic a, b, c, overflow;
  logic [$clog2(DEPTH):0] pending;
`ifdef COIN_RETURN_EN
  logic       coin_return;
  logic [1:0] return_code;
`endif

  coin_acceptor #(.DEB_CYCLES(DEB), .GAP_CYCLES(GAP), .FIFO_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .coin_a_raw (coin_a_raw),
    .coin_b_raw (coin_b_raw),
    .coin_c_raw (coin_c_raw),
    .hold       (hold),
    .a          (a),
    .b          (b),
    .c          (c),
    .pending    (pending),
    .overflow   (overflow)
`ifdef COIN_RETURN_EN
    ,
    .coin_return(coin_return),
    .return_code(return_code)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int         log_cyc[$];
  coin_code_t log_code[$];
  int         log_pend[$];
  int         onehot_err = 0;
  int         ret_cnt = 0;
  int         ret_last = 0;
  int         tests = 0;
  int         fails = 0;

  always @(negedge clk) begin
    if (reset) begin
      if (a | b | c) begin
        log_cyc.push_back(cyc);
        log_code.push_back(c ? COIN_C : (b ? COIN_B : COIN_A));
        log_pend.push_back(int'(pending));
      end
      if ($countones({a, b, c}) > 1) onehot_err++;
`ifdef COIN_RETURN_EN
      if (coin_return) begin
        ret_cnt++;
        ret_last = int'(return_code);
      end
`endif
    end
  end

  typedef struct {
    logic [2:0] raw;
    int         hi;
    int         exp_n;
    coin_code_t exp_code;
    int         exp_lat;
  } vec_t;

  vec_t vecs[7];

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic set_raw(input logic [2:0] v);
    {coin_c_raw, coin_b_raw, coin_a_raw} = v;
  endtask

  task automatic clear_log();
    log_cyc.delete();
    log_code.delete();
    log_pend.delete();
  endtask

  task automatic coin(input int ch, input int hi, input int lo);
    logic [2:0] v;
    v = 3'b000;
    v[ch] = 1'b1;
    set_raw(v);
    tick(hi);
    set_raw(3'b000);
    tick(lo);
  endtask

  task automatic wait_pulses(input int n, input int budget);
    int k = 0;
    while (log_cyc.size() < n && k < budget) begin
      tick(1);
      k++;
    end
    tick(10);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick(3);
    reset = 1'b1;
    tick(1);
    clear_log();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int t0;
    int total;
    coin_code_t exp_drain[6];

    vecs[0] = '{3'b010, 20, 1, COIN_B, LAT};
    vecs[1] = '{3'b001, 20, 1, COIN_A, LAT};
    vecs[2] = '{3'b100, 20, 1, COIN_C, LAT};
    vecs[3] = '{3'b001,  3, 0, COIN_NONE, 0};
    vecs[4] = '{3'b001,  4, 1, COIN_A, LAT};
    vecs[5] = '{3'b010,  3, 0, COIN_NONE, 0};
    vecs[6] = '{3'b100,  4, 1, COIN_C, LAT};

    exp_drain[0] = COIN_A; exp_drain[1] = COIN_B; exp_drain[2] = COIN_C;
    exp_drain[3] = COIN_A; exp_drain[4] = COIN_C; exp_drain[5] = COIN_B;

    // Reset and idle.
    tick(2);
    do_reset();
    tick(50);
    check("idle_a", int'(a), 0);
    check("idle_b", int'(b), 0);
    check("idle_c", int'(c), 0);
    check("idle_pending", int'(pending), 0);
    check("idle_overflow", int'(overflow), 0);
    check("idle_no_pulses", log_cyc.size(), 0);

    // Single-coin vector table, including the debounce-length boundary.
    for (int i = 0; i < 7; i++) begin
      clear_log();
      t0 = cyc;
      set_raw(vecs[i].raw);
      tick(vecs[i].hi);
      set_raw(3'b000);
      tick(40);
      check($sformatf("vec%0d_count", i), log_cyc.size(), vecs[i].exp_n);
      if (vecs[i].exp_n > 0 && log_cyc.size() > 0) begin
        check($sformatf("vec%0d_code", i), int'(log_code[0]), int'(vecs[i].exp_code));
        check($sformatf("vec%0d_latency", i), log_cyc[0] - t0, vecs[i].exp_lat);
      end
    end

    // Bouncing line: no coin while toggling, exactly one once it settles high.
    clear_log();
    for (int i = 0; i < 15; i++) begin
      coin_a_raw = ~coin_a_raw;
      tick(2);
    end
    check("bounce_no_event", log_cyc.size(), 0);
    coin_a_raw = 1'b1;
    tick(20);
    coin_a_raw = 1'b0;
    tick(30);
    check("bounce_settle_count", log_cyc.size(), 1);
    if (log_cyc.size() > 0) check("bounce_settle_code", int'(log_code[0]), int'(COIN_A));

    // Three simultaneous coins come out c, b, a, GAP+1 cycles apart.
    clear_log();
    t0 = cyc;
    set_raw(3'b111);
    tick(20);
    set_raw(3'b000);
    wait_pulses(3, 60);
    check("simul_count", log_cyc.size(), 3);
    if (log_cyc.size() == 3) begin
      check("simul_first_lat", log_cyc[0] - t0, LAT);
      check("simul_code0", int'(log_code[0]), int'(COIN_C));
      check("simul_code1", int'(log_code[1]), int'(COIN_B));
      check("simul_code2", int'(log_code[2]), int'(COIN_A));
      check("simul_space01", log_cyc[1] - log_cyc[0], GAP + 1);
      check("simul_space12", log_cyc[2] - log_cyc[1], GAP + 1);
    end

    // Hold queues coins; release drains them with pending counting down.
    clear_log();
    hold = 1'b1;
    coin(0, 10, 12);
    coin(1, 10, 12);
    coin(2, 10, 12);
    tick(5);
    check("hold_pending", int'(pending), 3);
    check("hold_no_pulses", log_cyc.size(), 0);
    t0 = cyc;
    hold = 1'b0;
    wait_pulses(3, 40);
    check("drain_count", log_cyc.size(), 3);
    if (log_cyc.size() == 3) begin
      check("drain_first_lat", log_cyc[0] - t0, 1);
      check("drain_code0", int'(log_code[0]), int'(COIN_A));
      check("drain_code2", int'(log_code[2]), int'(COIN_C));
      check("drain_pend0", log_pend[0], 2);
      check("drain_pend1", log_pend[1], 1);
      check("drain_pend2", log_pend[2], 0);
    end
    check("drain_pending_end", int'(pending), 0);

    // Full queue plus two waiting latches, then a repeat on a latched channel.
    clear_log();
    ret_cnt = 0;
    hold = 1'b1;
    coin(0, 10, 12);
    coin(1, 10, 12);
    coin(2, 10, 12);
    coin(0, 10, 12);
    coin(1, 10, 12);
    coin(2, 10, 12);
    tick(5);
    check("full_pending", int'(pending), DEPTH);
    check("full_no_overflow", int'(overflow), 0);
    coin(1, 10, 12);
    tick(5);
    check("drop_overflow", int'(overflow), 1);
    check("drop_pending", int'(pending), DEPTH);
    check("drop_no_pulses", log_cyc.size(), 0);
`ifdef COIN_RETURN_EN
    check("return_count", ret_cnt, 1);
    check("return_code", ret_last, int'(COIN_B));
`endif
    hold = 1'b0;
    wait_pulses(6, 80);
    check("ovf_drain_count", log_cyc.size(), 6);
    if (log_cyc.size() == 6) begin
      total = 0;
      for (int i = 0; i < 6; i++) begin
        check($sformatf("ovf_drain_code%0d", i), int'(log_code[i]), int'(exp_drain[i]));
        total += int'(coin_value(log_code[i]));
      end
      check("ovf_drain_value", total, 16);
    end
    check("overflow_sticky", int'(overflow), 1);

    // Mid-operation reset drops the queue; a line still high afterwards counts once.
    clear_log();
    hold = 1'b1;
    coin(0, 10, 12);
    check("rst_pre_pending", int'(pending), 1);
    coin_b_raw = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(1);
    check("rst_pending", int'(pending), 0);
    check("rst_overflow", int'(overflow), 0);
    check("rst_outputs", int'({a, b, c}), 0);
    tick(1);
    reset = 1'b1;
    clear_log();
    tick(15);
    coin_b_raw = 1'b0;
    hold = 1'b0;
    tick(30);
    check("rst_after_count", log_cyc.size(), 1);
    if (log_cyc.size() > 0) check("rst_after_code", int'(log_code[0]), int'(COIN_B));

    check("onehot_outputs", onehot_err, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
